// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: branch counter encoding, the PC
// increment and the PC value the fetch unit loads on reset.
//   cnt_t     : 2-bit saturating direction counter (upper bit = predict taken)
//   PC_STEP   : sequential fetch increment
//   PC_RESET  : fetch unit PC after reset; PC_RESET + PC_STEP wraps to 0
//   cnt_next  : saturating counter update for one resolved branch
package fetch_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] PC_RESET = 32'hFFFF_FFFC;

  function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
    cnt_t res;
    res = cnt;
    case (cnt)
      CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: res = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  res = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  res = taken ? CNT_ST  : CNT_WT;
      default: res = CNT_WNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch unit / execute stage and the next-PC controller.
//   pc, stall              : current fetch PC and hazard hold request
//   ex_*                   : branch resolution from execute
//   pc_write, next_pc      : PC register load enable and value
//   pred_taken/pred_target : prediction for the instruction at pc
//   flush                  : kill wrong-path instructions in IF/ID
// slave  = the sequencer side, master = the side driving pc/stall/ex_*.
interface fetch_sequencer_if;
  logic [31:0] pc;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  modport slave (
    input  pc, stall, ex_valid, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pc_write, next_pc, pred_taken, pred_target, flush
  );

  modport master (
    output pc, stall, ex_valid, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pc_write, next_pc, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
//   clock, reset      : rising-edge clock, asynchronous active-high clear
//   lookup_pc         : word address of the instruction being fetched
//   lookup_hit        : entry valid and tag matches
//   lookup_taken      : hit and counter predicts taken
//   lookup_target     : stored target of the indexed entry
//   upd_valid/pc/taken/target : one training write per cycle from execute
// Lookup is combinational and sees the contents before any same-cycle update.
module branch_target_buffer
  import fetch_pkg::*;
#(
  parameter  int IDX_BITS = 4,
  localparam int TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:2] lookup_pc,
  output logic        lookup_hit,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_valid,
  input  logic [31:2] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;

  assign lk_idx = lookup_pc[IDX_BITS+1:2];
  assign lk_tag = lookup_pc[31:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[31:IDX_BITS+2];

  // Per-entry state is exported into flat arrays for the read muxes.
  logic [ENTRIES-1:0]  valid_vec;
  logic [TAG_BITS-1:0] tag_vec    [ENTRIES];
  logic [31:0]         target_vec [ENTRIES];
  cnt_t                cnt_vec    [ENTRIES];

  assign lookup_hit    = valid_vec[lk_idx] && (tag_vec[lk_idx] == lk_tag);
  assign lookup_taken  = lookup_hit &&
                         ((cnt_vec[lk_idx] == CNT_WT) || (cnt_vec[lk_idx] == CNT_ST));
  assign lookup_target = target_vec[lk_idx];

  assign up_hit = valid_vec[up_idx] && (tag_vec[up_idx] == up_tag);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : gen_entry
      logic                valid_reg;
      logic [TAG_BITS-1:0] tag_reg;
      logic [31:0]         target_reg;
      cnt_t                cnt_reg;
      logic                sel;

      assign sel = upd_valid && (up_idx == IDX_BITS'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          cnt_reg    <= CNT_WNT;
        end else if (sel) begin
          if (up_hit) begin
            cnt_reg <= cnt_next(cnt_reg, upd_taken);
            if (upd_taken) target_reg <= upd_target;
          end else if (upd_taken) begin
            // Taken miss replaces whatever alias occupied this slot.
            valid_reg  <= 1'b1;
            tag_reg    <= up_tag;
            target_reg <= upd_target;
            cnt_reg    <= CNT_WT;
          end
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_vec[gi]    = tag_reg;
      assign target_vec[gi] = target_reg;
      assign cnt_vec[gi]    = cnt_reg;
    end
  endgenerate

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC controller for the instruction fetch unit.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : pc/stall/ex_* in; pc_write, next_pc, pred_taken,
//                  pred_target, flush out (all combinational)
// Priority: mispredict recovery > predicted taken > pc+4. A redirect
// overrides a hazard stall; training happens on every resolved branch.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic              clock,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  logic        hit;
  logic        lookup_taken;
  logic [31:0] lookup_target;
  logic [31:0] pc_plus4;
  logic [31:0] recovery_pc;
  logic        mispredict;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;

  branch_target_buffer #(.IDX_BITS(IDX_BITS)) u_btb (
    .clock         (clock),
    .reset         (reset),
    .lookup_pc     (bus.pc[31:2]),
    .lookup_hit    (hit),
    .lookup_taken  (lookup_taken),
    .lookup_target (lookup_target),
    .upd_valid     (bus.ex_valid),
    .upd_pc        (bus.ex_pc[31:2]),
    .upd_taken     (bus.ex_taken),
    .upd_target    (bus.ex_target)
  );

  // 32-bit add wraps naturally: PC_RESET + 4 = 0.
  assign pc_plus4    = bus.pc + PC_STEP;
  assign pred_taken  = lookup_taken;
  assign pred_target = hit ? lookup_target : pc_plus4;

  // Target mismatch only matters when the branch was actually taken.
  assign mispredict  = bus.ex_valid &&
                       ((bus.ex_taken != bus.ex_pred_taken) ||
                        (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
  assign recovery_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + PC_STEP);

  always_comb begin
    next_pc = pc_plus4;
    if (mispredict)      next_pc = recovery_pc;
    else if (pred_taken) next_pc = pred_target;
  end

  assign bus.next_pc     = next_pc;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.pc_write    = ~bus.stall | mispredict;
  assign bus.flush       = mispredict;

endmodule
